minmax_buf: RTL

//  Holds up to DEPTH entries and always offers the largest (MINMAX_=`High) or smallest (`Low) one.

---
 rtl/minmax_pkg.sv | 36 +++
 rtl/sel_minmax.sv | 36 +++
 rtl/minmax_buf.sv | 115 +++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// rtl/minmax_pkg.sv - select constants and helper functions for minmax_buf
// Purpose: `High/`Low polarity selects, priority-key width, lowest-free-slot encoder.
// Ports: none (package).
// Optional feature macro used by the bundle: MINMAX_BUF_FLUSH_EN.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

package minmax_pkg;

    localparam bit SEL_HIGH  = `High;
    localparam bit SEL_LOW   = `Low;
    // Widest slot vector the free-slot encoder handles; callers pad unused bits with 1.
    localparam int MAX_SLOTS = 64;

    // Key is {valid-flag, data}: one extra bit on top of the entry data.
    function automatic int key_width(input int data_w);
        return data_w + 1;
    endfunction

    // Index of the lowest clear bit; MAX_SLOTS when every bit is set.
    function automatic int lowest_free(input logic [MAX_SLOTS-1:0] valid_vec);
        int slot;
        slot = MAX_SLOTS;
        for (int i = MAX_SLOTS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                slot = i;
            end
        end
        return slot;
    endfunction

endpackage

// File: rtl/sel_minmax.sv
// rtl/sel_minmax.sv - combinational pick of the largest or smallest of IN packed values
// Purpose: scans IN values of width DATA, returns the extreme value and its index.
//   Direction is maximum when MINMAX_ equals ACT, minimum otherwise.
// Ports:
//   in       IN*DATA  packed values, element i at [i*DATA +: DATA]
//   out      DATA     winning value
//   out_idx  IW       index of the winning element (lowest index on ties)
module sel_minmax
    import minmax_pkg::*;
#(
    parameter bit MINMAX_ = SEL_HIGH,
    parameter int IN      = 8,
    parameter int DATA    = 9,
    parameter bit ACT     = SEL_HIGH,
    parameter int IW      = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic [IN*DATA-1:0] in,
    output logic [DATA-1:0]    out,
    output logic [IW-1:0]      out_idx
);

    localparam bit PICK_MAX = (MINMAX_ == ACT);

    // Linear scan; strict compare keeps the earliest index on equal values.
    always_comb begin
        out     = in[DATA-1:0];
        out_idx = '0;
        for (int i = 1; i < IN; i++) begin
            if (PICK_MAX ? (in[i*DATA +: DATA] > out) : (in[i*DATA +: DATA] < out)) begin
                out     = in[i*DATA +: DATA];
                out_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/minmax_buf.sv
// rtl/minmax_buf.sv - DEPTH-slot buffer that always offers its largest (`High) or smallest (`Low) entry
// Purpose: pushes fill the lowest free slot; consumer pops the current extreme entry.
//   Optional flush port enabled by macro MINMAX_BUF_FLUSH_EN.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_data    push request and data; in_ready = !full
//   out_valid/out_data  current extreme entry; out_idx = its slot; out_ready = pop
//   count, full, empty  occupancy
//   flush               (MINMAX_BUF_FLUSH_EN only) drop all entries
module minmax_buf
    import minmax_pkg::*;
#(
    parameter bit MINMAX_ = SEL_HIGH,
    parameter int DEPTH   = 8,
    parameter int DATA    = 8,
    parameter int IDX     = $clog2(DEPTH),
    parameter int CNT     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    output logic [IDX-1:0]  out_idx,
    input  logic            out_ready,
`ifdef MINMAX_BUF_FLUSH_EN
    input  logic            flush,
`endif
    output logic [CNT-1:0]  count,
    output logic            full,
    output logic            empty
);

    localparam int KW = key_width(DATA);

    logic [DEPTH-1:0]     valid;
    logic [DATA-1:0]      data [DEPTH];
    logic [DEPTH*KW-1:0]  key_vec;
    logic [KW-1:0]        sel_key;
    logic                 key_msb_unused;
    logic [MAX_SLOTS-1:0] valid_pad;
    logic [IDX-1:0]       free_idx;
    logic                 push;
    logic                 pop;

    assign full      = (count == CNT'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Slots beyond DEPTH are presented as occupied so they are never chosen.
    always_comb begin
        valid_pad              = '1;
        valid_pad[DEPTH-1:0]   = valid;
    end
    assign free_idx = IDX'(lowest_free(valid_pad));

    // The flag bit makes invalid slots lose: 0 under max, 1 under min.
    always_comb begin
        key_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            key_vec[i*KW +: KW] = MINMAX_ ? {valid[i], data[i]} : {~valid[i], data[i]};
        end
    end

    sel_minmax #(
        .MINMAX_ (MINMAX_),
        .IN      (DEPTH),
        .DATA    (KW),
        .ACT     (SEL_HIGH),
        .IW      (IDX)
    ) u_sel (
        .in      (key_vec),
        .out     (sel_key),
        .out_idx (out_idx)
    );

    assign out_data       = sel_key[DATA-1:0];
    assign key_msb_unused = sel_key[KW-1];

    // A popped slot is valid pre-edge, so it never collides with free_idx.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
        end
`ifdef MINMAX_BUF_FLUSH_EN
        else if (flush) begin
            valid <= '0;
            count <= '0;
        end
`endif
        else begin
            if (pop) begin
                valid[out_idx] <= 1'b0;
            end
            if (push) begin
                valid[free_idx] <= 1'b1;
            end
            count <= count + CNT'(push) - CNT'(pop);
        end
    end

    // Entry data is not reset; a slot's contents matter only while it is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data[free_idx] <= in_data;
        end
    end

endmodule
